// File: rtl/key_int_arb.sv
// Debounced key-release interrupt arbiter: per-channel sync + debounce, pending/lost
// tracking, lowest-index-first pulse arbiter. Optional macro KEYINT_ACK_EN: pulse ends on int_ack.
module key_int_arb #(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_CYC = 3,
    parameter int PULSE_CYC    = 6,
    parameter int GAP_CYC      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CH-1:0]                     press,
    input  logic                                  int_ack,
    output logic                                  interrupt,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] int_id,
    output logic [NUM_CH-1:0]                     pending,
    output logic                                  lost
);
    localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYC - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd1, GAP = 2'd2} state_t;

    logic [NUM_CH-1:0] sync1, sync2, db, rel_evt;
    logic [7:0]        db_cnt [NUM_CH];
    state_t            state, state_nx;
    logic [7:0]        ph_cnt, ph_cnt_nx;
    logic [IDW-1:0]    low_idx;
    logic              any_pend, take, int_nx;
    logic [NUM_CH-1:0] clr;

    // rel_evt is a one-cycle strobe on the edge where the debounced level falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            rel_evt <= '0;
            for (int i = 0; i < NUM_CH; i++) db_cnt[i] <= 8'd0;
        end else begin
            sync1   <= press;
            sync2   <= sync1;
            rel_evt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DEB_LAST) begin
                        db[i]      <= sync2[i];
                        db_cnt[i]  <= 8'd0;
                        rel_evt[i] <= ~sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= 8'd0;
                end
            end
        end
    end

    always_comb begin
        low_idx  = '0;
        any_pend = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx  = IDW'(i);
                any_pend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ph_cnt <= 8'd0;
        end else begin
            state  <= state_nx;
            ph_cnt <= ph_cnt_nx;
        end
    end

    // The last GAP cycle makes the IDLE decision itself, so back-to-back pulses
    // are separated by exactly GAP_CYC low cycles.
    always_comb begin
        state_nx  = state;
        ph_cnt_nx = ph_cnt;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    state_nx  = FIRE;
                    ph_cnt_nx = 8'd0;
                end
            end
            FIRE: begin
`ifdef KEYINT_ACK_EN
                if (int_ack) begin
                    state_nx  = GAP;
                    ph_cnt_nx = 8'd0;
                end
`else
                if (ph_cnt == PULSE_LAST) begin
                    state_nx  = GAP;
                    ph_cnt_nx = 8'd0;
                end else begin
                    ph_cnt_nx = ph_cnt + 8'd1;
                end
`endif
            end
            GAP: begin
                if (ph_cnt == GAP_LAST) begin
                    state_nx  = any_pend ? FIRE : IDLE;
                    ph_cnt_nx = 8'd0;
                end else begin
                    ph_cnt_nx = ph_cnt + 8'd1;
                end
            end
            default: begin
                state_nx  = IDLE;
                ph_cnt_nx = 8'd0;
            end
        endcase
    end

`ifndef KEYINT_ACK_EN
    logic unused_ack;
    assign unused_ack = int_ack;
`endif

    always_comb begin
        take   = (state_nx == FIRE) && (state != FIRE);
        int_nx = (state_nx == FIRE);
        clr    = take ? (NUM_CH'(1) << low_idx) : '0;
    end

    // A new event wins over a same-cycle clear, and is not counted as lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interrupt <= 1'b0;
            int_id    <= '0;
            pending   <= '0;
            lost      <= 1'b0;
        end else begin
            interrupt <= int_nx;
            if (take) int_id <= low_idx;
            pending   <= (pending & ~clr) | rel_evt;
            lost      <= lost | (|(rel_evt & pending & ~clr));
        end
    end
endmodule

// File: tb/tb_key_int_arb.sv
// Self-checking bench for key_int_arb with default parameters (fixed-length pulse build).
module tb_key_int_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] press = 4'b0;
    logic       int_ack = 1'b0;
    logic       interrupt;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic       lost;

    logic [1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    key_int_arb dut (
        .clk(clk), .rst_n(rst_n), .press(press), .int_ack(int_ack),
        .interrupt(interrupt), .int_id(int_id), .pending(pending), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        press = 4'b0;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_int got=%b exp=0", interrupt); end
        checks++; if (int_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", int_id); end
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", lost); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        logic exp_int;
        logic [1:0] e;
        press[2] = 1'b1;
        repeat (20) tick();
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL press_no_event got=%b exp=0000", pending); end
        press[2] = 1'b0;
        exp_q.push_back(2'd2);
        for (int k = 0; k <= 13; k++) begin
            tick();
            exp_int = (k >= 6) && (k <= 11);
            checks++; if (interrupt !== exp_int) begin failures++; $display("FAIL single_int k=%0d got=%b exp=%b", k, interrupt, exp_int); end
            if (k == 5) begin
                checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL single_pending got=%b exp=0100", pending); end
            end
            if (k == 6) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                checks++; if (int_id !== e) begin failures++; $display("FAIL single_id got=%0d exp=%0d", int_id, e); end
            end
        end
    endtask

    task automatic test_glitch();
        press[0] = 1'b1;
        tick(); tick();
        press[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++; if (interrupt !== 1'b0 || pending !== 4'b0) begin
                failures++; $display("FAIL glitch k=%0d int=%b pending=%b exp int=0 pending=0000", k, interrupt, pending);
            end
        end
    endtask

    task automatic test_two_same_cycle();
        logic exp_int, prev;
        logic [1:0] e;
        press = 4'b1010;
        repeat (10) tick();
        press = 4'b0;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        prev = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            exp_int = ((k >= 6) && (k <= 11)) || ((k >= 13) && (k <= 18));
            checks++; if (interrupt !== exp_int) begin failures++; $display("FAIL two_int k=%0d got=%b exp=%b", k, interrupt, exp_int); end
            if (k == 5) begin checks++; if (pending !== 4'b1010) begin failures++; $display("FAIL two_pending5 got=%b exp=1010", pending); end end
            if (k == 6) begin checks++; if (pending !== 4'b1000) begin failures++; $display("FAIL two_pending6 got=%b exp=1000", pending); end end
            if (k == 13) begin checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL two_pending13 got=%b exp=0000", pending); end end
            if (interrupt && !prev) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                checks++; if (int_id !== e) begin failures++; $display("FAIL two_id k=%0d got=%0d exp=%0d", k, int_id, e); end
            end
            prev = interrupt;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL two_missing_pulses left=%0d exp=0", exp_q.size()); end
    endtask

    // ch0..2 keep the arbiter busy so ch3 stays pending across its second release.
    task automatic test_lost();
        logic prev;
        logic [1:0] e;
        int rises = 0;
        press = 4'b1111;
        repeat (10) tick();
        press = 4'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
        prev = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            tick();
            if (k == 4) press[3] = 1'b1;
            if (k == 13) press[3] = 1'b0;
            if (k == 18) begin checks++; if (lost !== 1'b0) begin failures++; $display("FAIL lost_early got=%b exp=0", lost); end end
            if (k == 19) begin checks++; if (lost !== 1'b1) begin failures++; $display("FAIL lost_set got=%b exp=1", lost); end end
            if (interrupt && !prev) begin
                rises++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                checks++; if (int_id !== e) begin failures++; $display("FAIL lost_id k=%0d got=%0d exp=%0d", k, int_id, e); end
            end
            prev = interrupt;
        end
        checks++; if (rises != 4) begin failures++; $display("FAIL lost_pulses got=%0d exp=4", rises); end
        checks++; if (lost !== 1'b1 || pending !== 4'b0) begin failures++; $display("FAIL lost_sticky lost=%b pending=%b exp lost=1 pending=0000", lost, pending); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [1:0] e;
        bit seen = 0;
        press = 4'b0110;
        repeat (10) tick();
        press = 4'b0;
        exp_q.push_back(2'd1);
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if (interrupt) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_timeout got=no_pulse exp=pulse"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        checks++; if (int_id !== e) begin failures++; $display("FAIL rstmid_id got=%0d exp=%0d", int_id, e); end
        tick(); tick();
        checks++; if (interrupt !== 1'b1 || pending !== 4'b0100 || lost !== 1'b1) begin
            failures++; $display("FAIL rstmid_before int=%b pending=%b lost=%b exp 1 0100 1", interrupt, pending, lost);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (interrupt !== 1'b0 || pending !== 4'b0 || lost !== 1'b0) begin
            failures++; $display("FAIL rstmid_async int=%b pending=%b lost=%b exp 0 0000 0", interrupt, pending, lost);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rstmid_no_pulse k=%0d got=%b exp=0", k, interrupt); end
        end
    endtask

    task automatic test_held_through_reset();
        logic exp_int;
        logic [1:0] e;
        press[3] = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (interrupt !== 1'b0 || pending !== 4'b0) begin
                failures++; $display("FAIL held_no_event k=%0d int=%b pending=%b exp 0 0000", k, interrupt, pending);
            end
        end
        press[3] = 1'b0;
        exp_q.push_back(2'd3);
        for (int k = 0; k <= 13; k++) begin
            tick();
            exp_int = (k >= 6) && (k <= 11);
            checks++; if (interrupt !== exp_int) begin failures++; $display("FAIL held_int k=%0d got=%b exp=%b", k, interrupt, exp_int); end
            if (k == 6) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                checks++; if (int_id !== e) begin failures++; $display("FAIL held_id got=%0d exp=%0d", int_id, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_two_same_cycle();
        test_lost();
        test_reset_mid_pulse();
        test_held_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
